// File: rtl/dap_swj_seq_ctrl_pkg.sv
// dap_swj_seq_ctrl_pkg: shared DAP command codes, FSM encodings and chunk sizing helper for the SWJ sequence front-end.
package dap_swj_seq_ctrl_pkg;
  localparam logic [3:0] SEQ_CMD_SWJ_SEQ = 4'h3;
  localparam logic [7:0] ID_DAP_SWJ_SEQUENCE = 8'h12;
  localparam logic [7:0] DAP_OK = 8'h00;
  localparam logic [7:0] DAP_ERROR = 8'hFF;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_GAP = 3'd4;
  localparam logic [2:0] S_RESP_ID = 3'd5;
  localparam logic [2:0] S_RESP_ST = 3'd6;
  localparam logic [2:0] S_DRAIN = 3'd7;
  function automatic logic [6:0] chunk_of(input logic [8:0] rem);
    return rem > 9'd64 ? 7'd64 : rem[6:0];
  endfunction
endpackage

// File: rtl/dap_swj_seq_ctrl_packer.sv
// dap_seq_chunk_packer: collects payload bytes into a 64-bit chunk word, masks bits above the chunk length, flags the final byte.
module dap_seq_chunk_packer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wr,
  input  logic [2:0]  idx,
  input  logic [7:0]  data,
  input  logic [6:0]  bits,
  output logic [63:0] word,
  output logic        done
);
  logic [63:0] lanes;
  logic [63:0] mask;
  logic [6:0]  bits_m1;
  // Stale lanes from a previous chunk sit above the current bit count and are masked off.
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) lanes <= '0;
    else if (wr) lanes[{idx, 3'b000} +: 8] <= data;
  assign bits_m1 = bits - 7'd1;
  assign mask = bits[6] ? '1 : (64'd1 << bits[5:0]) - 64'd1;
  assign word = lanes & mask;
  assign done = wr && idx == bits_m1[5:3];
endmodule

// File: rtl/dap_swj_seq_ctrl.sv
// dap_swj_seq_ctrl: DAP_SWJ_Sequence front-end; chunks payload bits to the sequencer and returns the 2-byte response.
// Optional completion watchdog with payload drain and DAP_ERROR status: define SWJ_SEQ_TIMEOUT_EN.
module dap_swj_seq_ctrl
  import dap_swj_seq_ctrl_pkg::*;
#(
  parameter int MIN_GAP = 8,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        busy,
  output logic        seq_tx_valid,
  output logic [15:0] seq_tx_cmd,
  output logic [63:0] seq_tx_data,
  input  logic        seq_tx_full,
  input  logic        seq_rx_valid,
  input  logic [15:0] seq_rx_flag
);
  localparam int GW = $clog2(MIN_GAP + 1);
  if (MIN_GAP < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("dap_swj_seq_ctrl: MIN_GAP and TIMEOUT_CYCLES must be positive");
  end
  logic [2:0]    state;
  logic [8:0]    rem;
  logic [8:0]    left;
  logic [2:0]    idx;
  logic [GW-1:0] gap;
  logic          gap_done;
  logic          rx_q;
  logic          rx_rise;
  logic          take;
  logic [6:0]    chunk;
  logic [63:0]   word;
  logic          done;
  logic [7:0]    status;
  assign take = in_valid && in_ready;
  assign chunk = chunk_of(rem);
  assign left = rem - {2'b00, chunk};
  assign rx_rise = seq_rx_valid && !rx_q;
  assign gap_done = gap >= GW'(MIN_GAP - 1);
`ifdef SWJ_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo;
  logic [5:0]    drain;
  logic [9:0]    left_p7;
  logic [5:0]    drain_n;
  logic          tmo_hit;
  assign left_p7 = {1'b0, left} + 10'd7;
  assign drain_n = left_p7[8:3];
  assign tmo_hit = tmo == TW'(TIMEOUT_CYCLES - 1);
`else
  assign status = DAP_OK;
`endif
  dap_seq_chunk_packer u_packer (
    .clk    (clk),
    .resetn (resetn),
    .wr     (take && state == S_LOAD),
    .idx    (idx),
    .data   (in_data),
    .bits   (chunk),
    .word   (word),
    .done   (done)
  );
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= S_IDLE;
      rem <= '0;
      idx <= '0;
      gap <= '0;
      rx_q <= 1'b0;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      busy <= 1'b0;
      seq_tx_valid <= 1'b0;
      seq_tx_cmd <= '0;
      seq_tx_data <= '0;
`ifdef SWJ_SEQ_TIMEOUT_EN
      tmo <= '0;
      drain <= '0;
      status <= DAP_OK;
`endif
    end else begin
      rx_q <= seq_rx_valid;
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (take) begin
            rem <= {in_data == 8'd0, in_data};
            busy <= 1'b1;
            idx <= '0;
            state <= S_LOAD;
`ifdef SWJ_SEQ_TIMEOUT_EN
            status <= DAP_OK;
`endif
          end
        end
        S_LOAD: if (take) begin
          idx <= idx + 3'd1;
          if (done) begin
            in_ready <= 1'b0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: if (!seq_tx_full) begin
          seq_tx_valid <= 1'b1;
          seq_tx_cmd <= {SEQ_CMD_SWJ_SEQ, 5'd0, chunk};
          seq_tx_data <= word;
          state <= S_WAIT;
`ifdef SWJ_SEQ_TIMEOUT_EN
          tmo <= '0;
`endif
        end
        S_WAIT: begin
          if (rx_rise) begin
            seq_tx_valid <= 1'b0;
            rem <= left;
            gap <= '0;
            state <= S_GAP;
          end
`ifdef SWJ_SEQ_TIMEOUT_EN
          else if (tmo_hit) begin
            seq_tx_valid <= 1'b0;
            status <= DAP_ERROR;
            drain <= drain_n;
            if (drain_n == 6'd0) begin
              out_valid <= 1'b1;
              out_data <= ID_DAP_SWJ_SEQUENCE;
              state <= S_RESP_ID;
            end else begin
              in_ready <= 1'b1;
              state <= S_DRAIN;
            end
          end else tmo <= tmo + TW'(1);
`endif
        end
        // Hold off until the completion level is gone so every chunk gets a fresh rising edge.
        S_GAP: if (gap_done && !seq_rx_valid) begin
          if (rem != 9'd0) begin
            idx <= '0;
            in_ready <= 1'b1;
            state <= S_LOAD;
          end else begin
            out_valid <= 1'b1;
            out_data <= ID_DAP_SWJ_SEQUENCE;
            state <= S_RESP_ID;
          end
        end else if (!gap_done) gap <= gap + GW'(1);
        S_RESP_ID: if (out_ready) begin
          out_data <= status;
          state <= S_RESP_ST;
        end
        S_RESP_ST: if (out_ready) begin
          out_valid <= 1'b0;
          out_data <= '0;
          busy <= 1'b0;
          in_ready <= 1'b1;
          state <= S_IDLE;
        end
`ifdef SWJ_SEQ_TIMEOUT_EN
        S_DRAIN: if (take) begin
          drain <= drain - 6'd1;
          if (drain == 6'd1) begin
            in_ready <= 1'b0;
            out_valid <= 1'b1;
            out_data <= ID_DAP_SWJ_SEQUENCE;
            state <= S_RESP_ID;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  logic unused_flag;
  assign unused_flag = ^seq_rx_flag;
endmodule

// File: tb/tb_dap_swj_seq_ctrl.sv
// tb_dap_swj_seq_ctrl: scoreboard bench; expected sequencer requests and response bytes are queued from a reference model.
module tb_dap_swj_seq_ctrl;
  import dap_swj_seq_ctrl_pkg::*;
  localparam int MIN_GAP = 8;
  logic        clk = 0;
  logic        resetn = 1;
  logic        in_valid = 0;
  logic [7:0]  in_data = 0;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 0;
  logic        busy;
  logic        seq_tx_valid;
  logic [15:0] seq_tx_cmd;
  logic [63:0] seq_tx_data;
  logic        seq_tx_full = 0;
  logic        seq_rx_valid = 0;
  logic [15:0] seq_rx_flag = 16'hBEEF;
  int vectors = 0;
  int miscompares = 0;
  logic [79:0] exp_req[$];
  logic [7:0]  exp_rsp[$];
  logic [7:0]  pay[$];
  bit   hold_done = 0;
  bit   armed = 0;
  int   low_run = 0;
  logic tx_m = 0;
  logic tx_p = 0;
  dap_swj_seq_ctrl #(.MIN_GAP(MIN_GAP)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ready    (out_ready),
    .busy         (busy),
    .seq_tx_valid (seq_tx_valid),
    .seq_tx_cmd   (seq_tx_cmd),
    .seq_tx_data  (seq_tx_data),
    .seq_tx_full  (seq_tx_full),
    .seq_rx_valid (seq_rx_valid),
    .seq_rx_flag  (seq_rx_flag)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Sequencer stand-in: checks each new request, then returns a multi-cycle completion level.
  initial forever begin
    @(negedge clk);
    if (resetn && seq_tx_valid && !tx_p) begin
      check("req_pending", exp_req.size() != 0, 1);
      if (exp_req.size() != 0) check("req", {seq_tx_cmd, seq_tx_data}, exp_req.pop_front());
      if (!hold_done) begin
        repeat (3) @(negedge clk);
        seq_rx_valid = 1;
        repeat (4) @(negedge clk);
        seq_rx_valid = 0;
      end
    end
    tx_p = seq_tx_valid;
  end
  initial forever begin
    @(negedge clk);
    if (!resetn) begin
      armed = 0;
      low_run = 0;
    end else begin
      if (seq_tx_valid && !tx_m && armed) check("tx_gap", low_run >= MIN_GAP, 1);
      if (!seq_tx_valid && tx_m) begin
        armed = 1;
        low_run = 0;
      end
      if (!seq_tx_valid) low_run++;
    end
    tx_m = seq_tx_valid;
  end
  task automatic model(input int count);
    int rem = count == 0 ? 256 : count;
    int p = 0;
    while (rem > 0) begin
      int c = rem > 64 ? 64 : rem;
      int nb = (c + 7) / 8;
      logic [63:0] d = '0;
      for (int k = 0; k < nb; k++) d[8*k +: 8] = pay[p+k];
      if (c < 64) d = d & ((64'd1 << c) - 64'd1);
      exp_req.push_back({SEQ_CMD_SWJ_SEQ, 4'h0, 8'(c), d});
      p += nb;
      rem -= c;
    end
  endtask
  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    in_valid = 1;
    in_data = b;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check("in_ready_timeout", n, 0);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic get_rsp();
    out_ready = 1;
    for (int i = 0; i < 2; i++) begin
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 5000) begin
        @(negedge clk);
        n++;
      end
      check("rsp_timeout", n < 5000, 1);
      if (i == 0) check("req_drained", exp_req.size(), 0);
      check("rsp", out_data, exp_rsp.pop_front());
    end
    @(posedge clk);
    #1 out_ready = 0;
    @(negedge clk);
    check("busy_idle", busy, 0);
  endtask
  task automatic send_all(input int count);
    armed = 0;
    send(8'(count));
    foreach (pay[i]) send(pay[i]);
  endtask
  task automatic run(input int count);
    model(count);
    exp_rsp.push_back(ID_DAP_SWJ_SEQUENCE);
    exp_rsp.push_back(DAP_OK);
    send_all(count);
    get_rsp();
  endtask
  task automatic fill(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask
  initial begin
    int highs;
    int n;
    #1 resetn = 0;
    #11;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_tx_valid", seq_tx_valid, 0);
    check("rst_tx_cmd", seq_tx_cmd, 0);
    check("rst_tx_data", seq_tx_data, 0);
    @(negedge clk) resetn = 1;
    pay = '{8'hA5};
    run(8);
    pay = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h3F};
    run(70);
    fill(32);
    run(0);
    fill(2);
    run(13);
    fill(17);
    run(129);
    seq_tx_full = 1;
    pay = '{8'h5A};
    model(8);
    exp_rsp.push_back(ID_DAP_SWJ_SEQUENCE);
    exp_rsp.push_back(DAP_OK);
    send_all(8);
    highs = 0;
    repeat (50) begin
      @(negedge clk);
      highs += int'(seq_tx_valid);
    end
    check("full_hold", highs, 0);
    seq_tx_full = 0;
    @(negedge clk);
    check("full_release", seq_tx_valid, 1);
    get_rsp();
    hold_done = 1;
    pay = '{8'h3C};
    model(8);
    send_all(8);
    n = 0;
    while (!seq_tx_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_tx_valid", seq_tx_valid, 1);
    #2 resetn = 0;
    #1;
    check("arst_tx_valid", seq_tx_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_in_ready", in_ready, 0);
    check("arst_tx_cmd", seq_tx_cmd, 0);
    exp_req.delete();
    @(negedge clk) resetn = 1;
    hold_done = 0;
    pay = '{8'hA5};
    run(8);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
    $fatal(1, "watchdog");
  end
endmodule
